// File: rtl/fish_cut_counter.sv
// Per-frame cut-mask occupancy counter with a hysteresis FSM that counts fish passages.
// Optional FISH_MIN_DWELL_EN: passages shorter than MIN_DWELL occupied frames are rejected.
module fish_cut_counter #(
    parameter int OCC_W      = 16,
    parameter int CNT_W      = 16,
    parameter int TH_ON      = 64,
    parameter int TH_OFF     = 16,
    parameter int ON_FRAMES  = 2,
    parameter int OFF_FRAMES = 3,
    parameter int MIN_DWELL  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid_i,
    input  logic             mask_eq_i,
    input  logic             fg_i,
    input  logic             frame_end_i,
    input  logic             count_clr_i,
    output logic [OCC_W-1:0] frame_occ_o,
    output logic             occupied_o,
    output logic [CNT_W-1:0] fish_count_o,
    output logic             count_pulse_o,
    output logic             reject_pulse_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_OCC  = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

`ifdef FISH_MIN_DWELL_EN
    localparam bit DWELL_EN = 1'b1;
`else
    localparam bit DWELL_EN = 1'b0;
`endif

    logic [OCC_W-1:0] acc_q, acc_d, acc_inc_s, frame_occ_q, frame_occ_d;
    logic             eval_q;
    logic [1:0]       state_q, state_d;
    logic [7:0]       streak_q, streak_d, streak_inc_s;
    logic [7:0]       dwell_q, dwell_d, dwell_inc_s;
    logic [CNT_W-1:0] fish_count_q, fish_count_d;
    logic             occupied_q, count_pulse_q, reject_pulse_q;
    logic             pix_hit_s, hit_s, clear_s, exit_s, reject_s, count_s;

    assign pix_hit_s    = pix_valid_i & mask_eq_i & fg_i;
    assign acc_inc_s    = (pix_hit_s && (acc_q != {OCC_W{1'b1}})) ? acc_q + OCC_W'(1) : acc_q;
    assign hit_s        = 32'(frame_occ_q) >= TH_ON;
    assign clear_s      = 32'(frame_occ_q) < TH_OFF;
    assign streak_inc_s = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
    assign dwell_inc_s  = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;

    // Accumulator and frame latch; a pixel on the frame_end cycle belongs to the ending frame.
    always_comb begin
        acc_d       = acc_inc_s;
        frame_occ_d = frame_occ_q;
        if (frame_end_i) begin
            acc_d       = '0;
            frame_occ_d = acc_inc_s;
        end else begin
            acc_d       = acc_inc_s;
        end
    end

    // Hysteresis FSM, evaluated once per latched frame.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        dwell_d  = dwell_q;
        exit_s   = 1'b0;
        if (eval_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (hit_s) begin
                        if (ON_FRAMES == 1) begin
                            state_d  = ST_OCC;
                            streak_d = 8'd0;
                            dwell_d  = 8'd1;
                        end else begin
                            state_d  = ST_ARM;
                            streak_d = 8'd1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    if (hit_s) begin
                        if (32'(streak_inc_s) >= ON_FRAMES) begin
                            state_d  = ST_OCC;
                            streak_d = 8'd0;
                            dwell_d  = 8'd1;
                        end else begin
                            streak_d = streak_inc_s;
                        end
                    end else begin
                        state_d  = ST_IDLE;
                        streak_d = 8'd0;
                    end
                end
                ST_OCC: begin
                    dwell_d = dwell_inc_s;
                    if (clear_s) begin
                        if (OFF_FRAMES == 1) begin
                            exit_s = 1'b1;
                        end else begin
                            state_d  = ST_REL;
                            streak_d = 8'd1;
                        end
                    end else begin
                        state_d = ST_OCC;
                    end
                end
                ST_REL: begin
                    dwell_d = dwell_inc_s;
                    if (clear_s) begin
                        if (32'(streak_inc_s) >= OFF_FRAMES) begin
                            exit_s = 1'b1;
                        end else begin
                            streak_d = streak_inc_s;
                        end
                    end else begin
                        state_d  = ST_OCC;
                        streak_d = 8'd0;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    streak_d = 8'd0;
                    dwell_d  = 8'd0;
                end
            endcase
            if (exit_s) begin
                state_d  = ST_IDLE;
                streak_d = 8'd0;
                dwell_d  = 8'd0;
            end else begin
                state_d  = state_d;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Dwell is judged on the frames completed before the exit frame.
    assign reject_s = DWELL_EN && exit_s && (32'(dwell_q) < MIN_DWELL);
    assign count_s  = exit_s && !reject_s;

    // Fish counter: clear wins over a coincident increment, wraps silently.
    always_comb begin
        fish_count_d = fish_count_q;
        if (count_clr_i) begin
            fish_count_d = '0;
        end else if (count_s) begin
            fish_count_d = fish_count_q + CNT_W'(1);
        end else begin
            fish_count_d = fish_count_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q          <= '0;
            frame_occ_q    <= '0;
            eval_q         <= 1'b0;
            state_q        <= ST_IDLE;
            streak_q       <= 8'd0;
            dwell_q        <= 8'd0;
            fish_count_q   <= '0;
            occupied_q     <= 1'b0;
            count_pulse_q  <= 1'b0;
            reject_pulse_q <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            frame_occ_q    <= frame_occ_d;
            eval_q         <= frame_end_i;
            state_q        <= state_d;
            streak_q       <= streak_d;
            dwell_q        <= dwell_d;
            fish_count_q   <= fish_count_d;
            occupied_q     <= (state_d == ST_OCC) || (state_d == ST_REL);
            count_pulse_q  <= count_s;
            reject_pulse_q <= reject_s;
        end
    end

    assign frame_occ_o    = frame_occ_q;
    assign occupied_o     = occupied_q;
    assign fish_count_o   = fish_count_q;
    assign count_pulse_o  = count_pulse_q;
    assign reject_pulse_o = reject_pulse_q;

endmodule

// File: tb/tb_fish_cut_counter.sv
// Directed bench for fish_cut_counter: a default instance plus a narrow one (OCC_W=4, CNT_W=2)
// for saturation and count wrap; both share the same input stimulus.
module tb_fish_cut_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0, mask_eq = 1'b0, fg = 1'b0, frame_end = 1'b0, count_clr = 1'b0;
    logic [15:0] frame_occ, fish_count;
    logic        occupied, count_pulse, reject_pulse;
    logic [3:0]  s_frame_occ;
    logic [1:0]  s_fish_count;
    logic        s_occupied, s_count_pulse, s_reject_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int cp_cnt  = 0;
    int rj_cnt  = 0;
    int cp_base, rj_base;

    always #5 clk = ~clk;

    fish_cut_counter u_dut (
        .clk(clk), .rst(rst), .pix_valid_i(pix_valid), .mask_eq_i(mask_eq), .fg_i(fg),
        .frame_end_i(frame_end), .count_clr_i(count_clr), .frame_occ_o(frame_occ),
        .occupied_o(occupied), .fish_count_o(fish_count), .count_pulse_o(count_pulse),
        .reject_pulse_o(reject_pulse)
    );

    fish_cut_counter #(.OCC_W(4), .CNT_W(2), .TH_ON(8), .TH_OFF(2)) u_small (
        .clk(clk), .rst(rst), .pix_valid_i(pix_valid), .mask_eq_i(mask_eq), .fg_i(fg),
        .frame_end_i(frame_end), .count_clr_i(count_clr), .frame_occ_o(s_frame_occ),
        .occupied_o(s_occupied), .fish_count_o(s_fish_count), .count_pulse_o(s_count_pulse),
        .reject_pulse_o(s_reject_pulse)
    );

    // Pulse monitors on the default instance
    always @(posedge clk) begin
        if (count_pulse)  cp_cnt <= cp_cnt + 1;
        if (reject_pulse) rj_cnt <= rj_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // npix hit pixels, the last on the frame_end cycle; optional clear in the eval cycle
    task automatic run_frame(input int npix, input bit clr);
        if (npix == 0) begin
            frame_end = 1'b1;
            tick();
        end else begin
            for (int i = 0; i < npix; i++) begin
                pix_valid = 1'b1; mask_eq = 1'b1; fg = 1'b1;
                frame_end = (i == npix - 1);
                tick();
            end
        end
        pix_valid = 1'b0; mask_eq = 1'b0; fg = 1'b0; frame_end = 1'b0;
        count_clr = clr;
        tick();
        count_clr = 1'b0;
        repeat (4) tick();
    endtask

    task automatic passage(input bit clr);
        run_frame(80, 1'b0);
        run_frame(80, 1'b0);
        run_frame(80, 1'b0);
        run_frame(0, 1'b0);
        run_frame(0, 1'b0);
        run_frame(0, clr);
    endtask

    initial begin
        // Reset held with active pixels
        pix_valid = 1'b1; mask_eq = 1'b1; fg = 1'b1;
        repeat (3) tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        repeat (2) tick();
        check("rst_frame_occ", 32'(frame_occ), 32'd0);
        check("rst_occupied", 32'(occupied), 32'd0);
        check("rst_fish_count", 32'(fish_count), 32'd0);
        check("rst_count_pulse", 32'(count_pulse), 32'd0);
        check("rst_reject_pulse", 32'(reject_pulse), 32'd0);
        pix_valid = 1'b0; mask_eq = 1'b0; fg = 1'b0;
        rst = 1'b0;
        run_frame(10, 1'b0);
        check("first_frame_occ", 32'(frame_occ), 32'd10);
        check("band_idle_occupied", 32'(occupied), 32'd0);

        // Full passage 0,80,80,80,0,0,0
        do_reset();
        cp_base = cp_cnt;
        run_frame(0, 1'b0);
        run_frame(80, 1'b0);
        check("pass_occ_f2", 32'(occupied), 32'd0);
        run_frame(80, 1'b0);
        check("pass_occ_f3", 32'(occupied), 32'd1);
        run_frame(80, 1'b0);
        run_frame(0, 1'b0);
        run_frame(0, 1'b0);
        check("pass_occ_f6", 32'(occupied), 32'd1);
        run_frame(0, 1'b0);
        check("pass_occ_f7", 32'(occupied), 32'd0);
        check("pass_fish_count", 32'(fish_count), 32'd1);
        check("pass_pulses", 32'(cp_cnt - cp_base), 32'd1);

        // Clear coincident with the exit
        cp_base = cp_cnt;
        passage(1'b1);
        check("clr_fish_count", 32'(fish_count), 32'd0);
        check("clr_pulse", 32'(cp_cnt - cp_base), 32'd1);

        // Arming never completes
        run_frame(80, 1'b0);
        run_frame(0, 1'b0);
        run_frame(80, 1'b0);
        run_frame(0, 1'b0);
        check("arm_fish_count", 32'(fish_count), 32'd0);
        check("arm_occupied", 32'(occupied), 32'd0);

        // Saturation and frame_end pixel
        do_reset();
        run_frame(20, 1'b0);
        check("sat_small_occ", 32'(s_frame_occ), 32'd15);
        check("sat_big_occ", 32'(frame_occ), 32'd20);

        // Count wrap on the 2-bit instance
        do_reset();
        repeat (3) passage(1'b0);
        check("wrap_small_3", 32'(s_fish_count), 32'd3);
        check("wrap_big_3", 32'(fish_count), 32'd3);
        passage(1'b0);
        check("wrap_small_0", 32'(s_fish_count), 32'd0);
        check("wrap_big_4", 32'(fish_count), 32'd4);

        // Short dwell 80,80,0,0,0
        do_reset();
        rj_base = rj_cnt;
        run_frame(80, 1'b0);
        run_frame(80, 1'b0);
        run_frame(0, 1'b0);
        run_frame(0, 1'b0);
        run_frame(0, 1'b0);
        check("dwell_occupied", 32'(occupied), 32'd0);
`ifdef FISH_MIN_DWELL_EN
        check("dwell_fish_count", 32'(fish_count), 32'd0);
        check("dwell_reject", 32'(rj_cnt - rj_base), 32'd1);
`else
        check("dwell_fish_count", 32'(fish_count), 32'd1);
        check("dwell_reject", 32'(rj_cnt - rj_base), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
